// File: rtl/foo_handshake_arbiter.sv
// foo_handshake_arbiter: N-way round-robin ready/valid merge into a single
// registered output slot, reporting the winning source and a grant count.
module foo_handshake_arbiter #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned N     = 3,
  parameter int unsigned SRCW  = 2,
  parameter int unsigned CNTW  = 8
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  input  logic [WIDTH-1:0] in_data [N-1:0],
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [SRCW-1:0]  out_src,
  output logic [CNTW-1:0]  grant_count
);

  logic [SRCW-1:0]  last;
  logic [SRCW-1:0]  grant_idx;
  logic             grant_any;
  logic             accept_en;
  logic             transfer;
  logic [WIDTH-1:0] sel_data;

  // Slot can take a new beat when empty or draining this cycle.
  assign accept_en = !out_valid || out_ready;
  assign transfer  = ASYNCRESETN && accept_en && grant_any;

  // Round-robin pick: first valid channel after the last winner, wrapping.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (!grant_any && in_valid[i] && (((32'(last) + k) % N) == i)) begin
          grant_any = 1'b1;
          grant_idx = SRCW'(i);
        end
      end
    end
  end

  // Ready goes only to the winner, and only while the slot can accept.
  always_comb begin
    in_ready = '0;
    for (int unsigned i = 0; i < N; i++) begin
      in_ready[i] = transfer && (grant_idx == SRCW'(i));
    end
  end

  // Payload mux for the winning channel.
  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant_idx == SRCW'(i)) begin
        sel_data = in_data[i];
      end
    end
  end

  // Output slot, last-grant pointer and grant counter.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_src     <= '0;
      last        <= SRCW'(N - 1);
      grant_count <= '0;
    end else if (transfer) begin
      out_valid   <= 1'b1;
      out_data    <= sel_data;
      out_src     <= grant_idx;
      last        <= grant_idx;
      grant_count <= grant_count + CNTW'(1);
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_foo_handshake_arbiter.sv
// Bench for foo_handshake_arbiter: directed stimulus with a queue-based
// scoreboard checked whenever the output beat is consumed.
module tb_foo_handshake_arbiter;

  typedef struct {
    logic [4:0] d;
    logic [1:0] s;
    logic [7:0] c;
  } exp_t;

  logic       CLK = 1'b0;
  logic       ASYNCRESETN;
  logic [2:0] in_valid;
  logic [2:0] in_ready;
  logic [4:0] in_data [2:0];
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_data;
  logic [1:0] out_src;
  logic [7:0] grant_count;

  int   checks   = 0;
  int   failures = 0;
  exp_t q[$];
  exp_t mon_e;
  logic [7:0] exp_cnt;
  logic [1:0] exp_last;
  logic [1:0] nxt;

  always #5 CLK = ~CLK;

  foo_handshake_arbiter #(.WIDTH(5), .N(3), .SRCW(2), .CNTW(8)) dut (
    .CLK         (CLK),
    .ASYNCRESETN (ASYNCRESETN),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_src     (out_src),
    .grant_count (grant_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every consumed output beat must match the head of the queue.
  always @(negedge CLK) begin
    if (ASYNCRESETN === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_beat", 32'd1, 32'd0);
      end else begin
        mon_e = q.pop_front();
        chk("beat_data", 32'(out_data), 32'(mon_e.d));
        chk("beat_src", 32'(out_src), 32'(mon_e.s));
        chk("beat_count", 32'(grant_count), 32'(mon_e.c));
      end
    end
  end

  // Present valids, expect channel s to win at the coming edge.
  task automatic beat(input logic [2:0] v, input logic [1:0] s);
    logic [2:0] onehot;
    onehot   = 3'b001 << s;
    in_valid = v;
    @(negedge CLK);
    chk("in_ready", 32'(in_ready), 32'(onehot));
    q.push_back('{d: in_data[s], s: s, c: exp_cnt + 8'd1});
    exp_cnt  = exp_cnt + 8'd1;
    exp_last = s;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 3'b000;
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    logic [1:0] cont_seq [6];
    logic [1:0] skip_seq [4];
    cont_seq = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    skip_seq = '{2'd2, 2'd0, 2'd2, 2'd0};

    ASYNCRESETN = 1'b0;
    in_valid    = 3'b111;
    out_ready   = 1'b1;
    in_data[0]  = 5'h01;
    in_data[1]  = 5'h02;
    in_data[2]  = 5'h03;
    exp_cnt     = 8'd0;
    exp_last    = 2'd2;

    // Reset state, with all inputs requesting.
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_src", 32'(out_src), 32'd0);
    chk("rst_grant_count", 32'(grant_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    in_valid = 3'b000;
    @(negedge CLK);
    ASYNCRESETN = 1'b1;
    @(posedge CLK);
    #1;

    // Full contention: 0,1,2,0,1,2 back to back.
    for (int k = 0; k < 6; k++) begin
      beat(3'b111, cont_seq[k]);
      chk("contention_valid", 32'(out_valid), 32'd1);
    end

    // Single requester on port 1.
    in_data[1] = 5'h15;
    beat(3'b010, 2'd1);
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_data", 32'(out_data), 32'h15);
    chk("single_src", 32'(out_src), 32'd1);
    chk("single_count", 32'(grant_count), 32'd7);

    // Idle port 1 is skipped; last=1 so port 2 leads.
    in_data[0] = 5'h04;
    in_data[2] = 5'h06;
    for (int k = 0; k < 4; k++) begin
      beat(3'b101, skip_seq[k]);
    end

    // Backpressure: hold port 0 beat while everyone requests.
    in_data[0] = 5'h0A;
    beat(3'b001, 2'd0);
    in_data[1] = 5'h0B;
    in_data[2] = 5'h0C;
    out_ready  = 1'b0;
    in_valid   = 3'b111;
    repeat (4) begin
      @(negedge CLK);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", 32'(out_data), 32'h0A);
      chk("stall_src", 32'(out_src), 32'd0);
      chk("stall_count", 32'(grant_count), 32'(exp_cnt));
      @(posedge CLK);
      #1;
    end
    out_ready = 1'b1;
    beat(3'b111, 2'd1);

    // Long run through the counter wrap (255 -> 0).
    in_data[0] = 5'h11;
    in_data[1] = 5'h12;
    in_data[2] = 5'h13;
    for (int k = 0; k < 250; k++) begin
      nxt = (exp_last == 2'd2) ? 2'd0 : exp_last + 2'd1;
      beat(3'b111, nxt);
    end
    chk("wrap_count", 32'(grant_count), 32'd7);
    idle(2);

    // Reset during a stalled beat from port 1.
    out_ready  = 1'b0;
    in_data[1] = 5'h1E;
    in_valid   = 3'b010;
    @(posedge CLK);
    #1;
    in_valid = 3'b111;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2;
    ASYNCRESETN = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_count", 32'(grant_count), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    in_valid = 3'b000;
    #2;
    ASYNCRESETN = 1'b1;
    exp_cnt  = 8'd0;
    exp_last = 2'd2;
    out_ready = 1'b1;
    @(posedge CLK);
    #1;
    beat(3'b111, 2'd0);
    chk("post_rst_src", 32'(out_src), 32'd0);
    chk("post_rst_count", 32'(grant_count), 32'd1);

    idle(3);
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/foo_handshake_arbiter.md
# foo_handshake_arbiter

Three-way round-robin arbiter with a single registered output slot. It merges the `handshake_arr_0..2` ready/valid channels, each carrying a 5-bit payload, onto the single `handshake` channel and the `in1` payload that feed `foo_RTL_unq1`. It sits directly upstream of `foo_RTL_unq1`, so the bound monitor observes its output channel. It grants at most one input per cycle, holds the granted beat stable under backpressure, and reports which source won.

## Interface
- `WIDTH`, default 5: payload width in bits.
- `N`, default 3: number of input channels. Supported range is 2..4.
- `SRCW`, default 2: source-index width. Must be at least ceil(log2(N)).
- `CNTW`, default 8: width of the grant counter.

Ports:
- `CLK`  in  1: clock, rising edge.
- `ASYNCRESETN`  in  1: asynchronous reset, active-low. Assertion clears state immediately; deassertion is synchronous to `CLK`.
- `in_valid`  in  N: per-channel valid (`handshake_arr_i_valid`).
- `in_ready`  out  N: per-channel ready (`handshake_arr_i_ready`).
- `in_data`  in  WIDTH x N (unpacked `[WIDTH-1:0] in_data [N-1:0]`): per-channel payload.
- `out_valid`  out  1: output beat valid (`handshake_valid`).
- `out_ready`  in  1: downstream ready (`handshake_ready`).
- `out_data`  out  WIDTH: payload of the held beat (`in1`).
- `out_src`  out  SRCW: index of the channel that produced the held beat.
- `grant_count`  out  CNTW: total grants since reset, modulo 2^CNTW.

## Operation
- State: one output slot (`out_valid`, `out_data`, `out_src`), a last-grant pointer `last` (SRCW bits), and `grant_count`.
- `accept_en = !out_valid || out_ready`. The slot is empty, or it drains this cycle.
- Priority order is `last+1, last+2, ..., last` modulo N. The grant goes to the first channel in that order with `in_valid` high.
- `in_ready[i] = accept_en && (i == grant)`. This is combinational from `in_valid`, `out_valid` and `out_ready`. At most one bit is high per cycle. All bits are low when no input is valid.
- Transfer on input i happens when `in_valid[i] && in_ready[i]`. On that edge:
  - `out_data <= in_data[i]`, `out_src <= i`, `out_valid <= 1`.
  - `last <= i`.
  - `grant_count <= grant_count + 1`, wrapping from 2^CNTW-1 to 0.
- Drain with no new grant (`out_valid && out_ready` and no input transfer): `out_valid <= 0`. `out_data` and `out_src` hold their last values.
- Stall (`out_valid && !out_ready`): `out_data`, `out_src` and `out_valid` hold. Every `in_ready` bit is 0.
- Simultaneous drain and grant: the slot is replaced in the same edge, so `out_valid` stays 1. This sustains 1 beat/cycle.
- An `in_valid` that is not granted is not consumed. The source must hold its valid and data (standard ready/valid rule). The arbiter never drops or duplicates a beat.
- Fairness: with all N inputs continuously valid and `out_ready=1`, the grant sequence is 0,1,...,N-1,0,... No input waits more than N-1 grants.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_src=0`, `last=N-1` (so port 0 has first priority), `grant_count=0`. All `in_ready` bits are 0 during reset.
- Latency: a beat accepted at edge k is visible on `out_*` after edge k. Input-to-output latency is 1 cycle.
- Throughput: 1 beat/cycle when `out_ready` is held high.
- `out_valid`, once high, stays high until the cycle in which `out_ready` is high. `out_data` and `out_src` are stable over that window.
- Reset asserted mid-transfer: the slot is discarded, all state returns to its reset value asynchronously, and no grant is counted for that cycle.
- No combinational path from `in_valid` or `in_data` to `out_valid` or `out_data`. `out_ready` reaches `in_ready` combinationally.

## Test plan
- Single requester: `in_valid=3'b010`, `in_data[1]=5'h15`, `out_ready=1` → `in_ready=3'b010`. Next cycle `out_valid=1`, `out_data=5'h15`, `out_src=1`, `grant_count=1`.
- Full contention: all valid, distinct data `5'h01/5'h02/5'h03`, `out_ready=1` for 6 cycles → `out_src` sequence 0,1,2,0,1,2, with `out_valid` high on every cycle after the first.
- Skip idle port: only ports 0 and 2 valid, `out_ready=1` → grants alternate 0,2,0,2. `in_ready[1]` is never high.
- Backpressure: grant from port 0 with `5'h0A`, then `out_ready=0` for 4 cycles while all inputs are valid → `out_data=5'h0A` and `out_src=0` held, `in_ready=0`, `grant_count` unchanged. On `out_ready=1`, port 1 is granted in that same cycle.
- Counter wrap: 256 consecutive grants → `grant_count` reads 255 then 0.
- Reset mid-operation: assert `ASYNCRESETN=0` between edges while `out_valid=1` → `out_valid=0` and `grant_count=0` immediately. After release, the first grant goes to port 0 when all inputs are valid.
